lfu_buf_ctrl: RTL and testbench
===============================

# lfu_buf_ctrl

Tag-lookup and allocation controller for the 4-entry buffer pool. It is the requesting side of the LFU replacement finder. It accepts tag lookups over a valid/ready handshake and compares each against four tag registers. On a hit it reports a reference to the finder. On a miss it either fills the lowest invalid entry or requests a victim from the finder, installs the tag, and returns the buffer number with a hit/miss flag.

## Interface
Parameters:
- TAG_W, 8, tag width in bits
- BUF_BIT, 2, buffer index width (4 entries; fixed)
- REPLC_LAT, 2, cycles from lfu_new_req assertion to a valid lfu_replc_buf (1..3)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_vld  in  1  lookup request valid
- req_tag  in  TAG_W  lookup tag
- req_rdy  out  1  controller can accept a request
- rsp_vld  out  1  response valid, held until rsp_rdy
- rsp_rdy  in  1  response consumer ready
- rsp_buf  out  BUF_BIT  buffer number holding the tag
- rsp_hit  out  1  1 = hit, 0 = miss/fill
- flush  in  1  invalidate all entries (sampled in IDLE only)
- lfu_ref_vld  out  1  one-cycle pulse: entry referenced
- lfu_ref_buf  out  BUF_BIT  referenced entry index
- lfu_new_req  out  1  one-cycle pulse: victim requested
- lfu_replc_buf  in  BUF_BIT  victim index from finder

## Operation
- State: tag[0..3] (TAG_W each), vld[3:0], FSM {IDLE, LOOKUP, ALLOC, WAIT, RESP}, latency counter (2 bits), registered request tag.
- IDLE: req_rdy=1. If flush=1, clear vld to 0000 and stay in IDLE; req_rdy=0 that cycle, so flush has priority over req_vld. Else on req_vld, capture req_tag and go to LOOKUP.
- LOOKUP: compare the captured tag against all entries with vld=1. Multiple matches cannot occur by construction; if they do, the lowest index wins.
  - Hit at index i: pulse lfu_ref_vld with lfu_ref_buf=i, set rsp_buf=i and rsp_hit=1, go to RESP.
  - Miss with any vld bit 0: fill the lowest invalid index j. Write tag[j], set vld[j], pulse lfu_ref_vld with lfu_ref_buf=j. No lfu_new_req is issued. Set rsp_buf=j and rsp_hit=0, go to RESP.
  - Miss with vld=1111: go to ALLOC.
- ALLOC: pulse lfu_new_req for exactly one cycle, load the counter with REPLC_LAT, go to WAIT.
- WAIT: decrement the counter. When it reaches 0, sample lfu_replc_buf=k, write tag[k] (vld[k] stays 1), set rsp_buf=k and rsp_hit=0, go to RESP.
- RESP: rsp_vld=1; rsp_buf and rsp_hit are stable. When rsp_rdy=1, go to IDLE.
- lfu_ref_vld and lfu_new_req are never asserted in the same cycle. At most one of them is asserted per request.
- Tag/vld writes take effect on the clock edge that leaves LOOKUP or WAIT. A following lookup of the same tag therefore hits.

## Timing
- Reset values:
  - FSM=IDLE, vld=0000, tags=0.
  - req_rdy=1 (combinational from IDLE && !flush).
  - rsp_vld=0, rsp_buf=0, rsp_hit=0.
  - lfu_ref_vld=0, lfu_ref_buf=0, lfu_new_req=0.
- Reset asserted mid-operation aborts the transaction: no response is produced, all state returns to reset values, and any pending lfu pulse is dropped.
- All outputs are registered except req_rdy.
- Latencies, measured from the handshake edge (req_vld&&req_rdy) to rsp_vld=1:
  - Hit or fill: 2 cycles.
  - Replace: 3+REPLC_LAT cycles.
- The lfu_ref_vld pulse coincides with the first cycle of rsp_vld for a hit or fill.
- Back-to-back operation:
  - rsp_rdy held high gives one request per 3 cycles for hits (IDLE, LOOKUP, RESP).
  - rsp_rdy low stalls in RESP indefinitely; req_rdy stays 0.
- flush in a non-IDLE state is ignored. The requester must hold flush until it sees req_rdy return high and the flush accepted in IDLE.

## Test plan
- Fill: after reset, lookups of tags 0x11, 0x22, 0x33, 0x44 -> rsp_hit=0 with rsp_buf=0,1,2,3 in turn. lfu_ref_vld pulses with the same indices; lfu_new_req never asserts.
- Hit: after the fill, lookup 0x33 -> rsp_hit=1, rsp_buf=2, one lfu_ref_vld pulse with lfu_ref_buf=2, response 2 cycles after the handshake.
- Replace: with the pool full, lookup 0x55 while lfu_replc_buf is driven to 1 -> one lfu_new_req pulse, rsp_buf=1, rsp_hit=0, response at 3+REPLC_LAT cycles. A following lookup of 0x55 hits buf 1; a lookup of 0x22 misses.
- Backpressure: hold rsp_rdy=0 for 10 cycles on a hit -> rsp_vld, rsp_buf and rsp_hit stay stable, req_rdy=0 throughout, no extra lfu pulses.
- Flush: assert flush and req_vld together in IDLE -> vld cleared, request not accepted that cycle. The next lookup of 0x11 is a miss filled into buf 0.
- Reset mid-WAIT: assert rst during WAIT -> all outputs return to reset values at once, rsp_vld never asserts, and the next lookup of 0x11 fills buf 0.

Source files
------------

// File: rtl/lfu_buf_ctrl_if.sv
// Signal bundle between lfu_buf_ctrl, its lookup requester/response consumer
// and the LFU replacement finder.
interface lfu_buf_ctrl_if #(
    parameter int TAG_W   = 8,
    parameter int BUF_BIT = 2
);
    logic               req_vld;
    logic [TAG_W-1:0]   req_tag;
    logic               req_rdy;
    logic               rsp_vld;
    logic               rsp_rdy;
    logic [BUF_BIT-1:0] rsp_buf;
    logic               rsp_hit;
    logic               flush;
    logic               lfu_ref_vld;
    logic [BUF_BIT-1:0] lfu_ref_buf;
    logic               lfu_new_req;
    logic [BUF_BIT-1:0] lfu_replc_buf;

    modport slave (
        input  req_vld, req_tag, rsp_rdy, flush, lfu_replc_buf,
        output req_rdy, rsp_vld, rsp_buf, rsp_hit,
               lfu_ref_vld, lfu_ref_buf, lfu_new_req
    );

    modport master (
        output req_vld, req_tag, rsp_rdy, flush, lfu_replc_buf,
        input  req_rdy, rsp_vld, rsp_buf, rsp_hit,
               lfu_ref_vld, lfu_ref_buf, lfu_new_req
    );
endinterface

// File: rtl/lfu_buf_ctrl.sv
// Tag lookup / allocation controller for a 4-entry buffer pool; hits and fills
// report a reference to the LFU finder, full-pool misses ask it for a victim.
module lfu_buf_ctrl #(
    parameter int TAG_W     = 8,
    parameter int BUF_BIT   = 2,
    parameter int REPLC_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    lfu_buf_ctrl_if.slave bus
);
    localparam int NBUF = 1 << BUF_BIT;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_ALLOC  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t             state_q, state_d;

    logic [TAG_W-1:0]   tag_q [NBUF];
    logic [TAG_W-1:0]   tag_d [NBUF];
    logic [NBUF-1:0]    vld_q, vld_d;
    logic [TAG_W-1:0]   rtag_q, rtag_d;
    logic [1:0]         cnt_q, cnt_d;

    logic               rsp_vld_q, rsp_vld_d;
    logic [BUF_BIT-1:0] rsp_buf_q, rsp_buf_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic               ref_vld_q, ref_vld_d;
    logic [BUF_BIT-1:0] ref_buf_q, ref_buf_d;
    logic               new_req_q, new_req_d;

    logic               hit;
    logic               full;
    logic               wait_done;
    logic [BUF_BIT-1:0] hit_idx;
    logic [BUF_BIT-1:0] free_idx;

    // Descending scan so the lowest matching / lowest free index is the one left.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = NBUF - 1; i >= 0; i--) begin
            if (vld_q[i] && (tag_q[i] == rtag_q)) begin
                hit     = 1'b1;
                hit_idx = BUF_BIT'(i);
            end
            if (!vld_q[i]) begin
                free_idx = BUF_BIT'(i);
            end
        end
    end

    assign full      = &vld_q;
    assign wait_done = (cnt_q == 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.flush && bus.req_vld) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit || !full) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_ALLOC;
                end
            end
            S_ALLOC: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values for the tag store and every registered output.
    always_comb begin
        tag_d     = tag_q;
        vld_d     = vld_q;
        rtag_d    = rtag_q;
        cnt_d     = cnt_q;
        rsp_buf_d = rsp_buf_q;
        rsp_hit_d = rsp_hit_q;
        ref_buf_d = ref_buf_q;
        ref_vld_d = 1'b0;
        new_req_d = 1'b0;
        rsp_vld_d = (state_d == S_RESP);
        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    vld_d = '0;
                end else if (bus.req_vld) begin
                    rtag_d = bus.req_tag;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    ref_vld_d = 1'b1;
                    ref_buf_d = hit_idx;
                    rsp_buf_d = hit_idx;
                    rsp_hit_d = 1'b1;
                end else if (!full) begin
                    tag_d[free_idx] = rtag_q;
                    vld_d[free_idx] = 1'b1;
                    ref_vld_d       = 1'b1;
                    ref_buf_d       = free_idx;
                    rsp_buf_d       = free_idx;
                    rsp_hit_d       = 1'b0;
                end else begin
                    new_req_d = 1'b1;
                end
            end
            S_ALLOC: begin
                cnt_d = 2'(REPLC_LAT);
            end
            S_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (wait_done) begin
                    tag_d[bus.lfu_replc_buf] = rtag_q;
                    rsp_buf_d                = bus.lfu_replc_buf;
                    rsp_hit_d                = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBUF; i++) begin
                tag_q[i] <= '0;
            end
            vld_q     <= '0;
            rtag_q    <= '0;
            cnt_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_buf_q <= '0;
            rsp_hit_q <= 1'b0;
            ref_vld_q <= 1'b0;
            ref_buf_q <= '0;
            new_req_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            vld_q     <= vld_d;
            rtag_q    <= rtag_d;
            cnt_q     <= cnt_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_buf_q <= rsp_buf_d;
            rsp_hit_q <= rsp_hit_d;
            ref_vld_q <= ref_vld_d;
            ref_buf_q <= ref_buf_d;
            new_req_q <= new_req_d;
        end
    end

    assign bus.req_rdy     = (state_q == S_IDLE) && !bus.flush;
    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_buf     = rsp_buf_q;
    assign bus.rsp_hit     = rsp_hit_q;
    assign bus.lfu_ref_vld = ref_vld_q;
    assign bus.lfu_ref_buf = ref_buf_q;
    assign bus.lfu_new_req = new_req_q;

endmodule

// File: tb/tb_lfu_buf_ctrl.sv
// Scoreboard bench for lfu_buf_ctrl: a tag-pool model predicts each response
// and each LFU pulse, which are compared as the DUT produces them.
module tb_lfu_buf_ctrl;
    localparam int TAG_W     = 8;
    localparam int BUF_BIT   = 2;
    localparam int REPLC_LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] replc_sel;

    lfu_buf_ctrl_if #(.TAG_W(TAG_W), .BUF_BIT(BUF_BIT)) bus ();

    lfu_buf_ctrl #(
        .TAG_W    (TAG_W),
        .BUF_BIT  (BUF_BIT),
        .REPLC_LAT(REPLC_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    assign bus.lfu_replc_buf = replc_sel;

    typedef struct packed {
        logic [1:0] bufi;
        logic       hit;
    } rsp_t;

    typedef struct packed {
        logic       is_new;
        logic [1:0] bufi;
    } pls_t;

    rsp_t       rsp_q [$];
    pls_t       pls_q [$];
    logic [7:0] m_tag [4];
    logic [3:0] m_vld;
    int         exp_lat;
    int         n_pulse = 0;
    int         n_chk   = 0;
    int         n_err   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every LFU pulse is matched against the model's expectation.
    always @(negedge clk) begin
        if (!rst && (bus.lfu_ref_vld || bus.lfu_new_req)) begin
            pls_t p;
            n_pulse++;
            chk("pulse_excl", 32'(bus.lfu_ref_vld & bus.lfu_new_req), 32'(0));
            chk("pulse_expected", 32'(pls_q.size() != 0), 32'(1));
            if (pls_q.size() != 0) begin
                p = pls_q.pop_front();
                chk("pulse_kind", 32'(bus.lfu_new_req), 32'(p.is_new));
                if (p.is_new) begin
                    chk("new_before_rsp", 32'(bus.rsp_vld), 32'(0));
                end else begin
                    chk("ref_buf", 32'(bus.lfu_ref_buf), 32'(p.bufi));
                    chk("ref_with_rsp", 32'(bus.rsp_vld), 32'(1));
                end
            end
        end
    end

    task automatic start_req(input logic [7:0] tag);
        int   idx;
        rsp_t r;
        pls_t p;
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (idx < 0 && m_vld[i] && m_tag[i] == tag) idx = i;
        end
        if (idx >= 0) begin
            r.bufi = 2'(idx); r.hit = 1'b1;
            p.is_new = 1'b0; p.bufi = 2'(idx);
            exp_lat = 2;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (idx < 0 && !m_vld[i]) idx = i;
            end
            if (idx >= 0) begin
                m_vld[idx] = 1'b1;
                p.is_new = 1'b0; p.bufi = 2'(idx);
                exp_lat = 2;
            end else begin
                idx = int'(replc_sel);
                p.is_new = 1'b1; p.bufi = 2'd0;
                exp_lat = 3 + REPLC_LAT;
            end
            m_tag[idx] = tag;
            r.bufi = 2'(idx); r.hit = 1'b0;
        end
        rsp_q.push_back(r);
        pls_q.push_back(p);
        @(negedge clk);
        bus.req_vld = 1'b1;
        bus.req_tag = tag;
        chk("req_rdy", 32'(bus.req_rdy), 32'(1));
    endtask

    task automatic finish_req(input int stall);
        int   cyc;
        int   p0;
        rsp_t e;
        p0  = n_pulse;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            bus.req_vld = 1'b0;
            cyc++;
            if (bus.rsp_vld || cyc > 20) break;
        end
        chk("rsp_seen", 32'(bus.rsp_vld), 32'(1));
        e = rsp_q.pop_front();
        if (bus.rsp_vld) begin
            chk("latency", cyc, exp_lat);
            chk("rsp_buf", 32'(bus.rsp_buf), 32'(e.bufi));
            chk("rsp_hit", 32'(bus.rsp_hit), 32'(e.hit));
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_vld", 32'(bus.rsp_vld), 32'(1));
                chk("stall_buf", 32'(bus.rsp_buf), 32'(e.bufi));
                chk("stall_hit", 32'(bus.rsp_hit), 32'(e.hit));
                chk("stall_rdy", 32'(bus.req_rdy), 32'(0));
            end
            bus.rsp_rdy = 1'b1;
            @(negedge clk);
            chk("rsp_done", 32'(bus.rsp_vld), 32'(0));
            chk("idle_rdy", 32'(bus.req_rdy), 32'(1));
        end
        chk("pulse_count", n_pulse - p0, 1);
    endtask

    task automatic lookup(input logic [7:0] tag, input int stall);
        start_req(tag);
        if (stall > 0) bus.rsp_rdy = 1'b0;
        finish_req(stall);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_rsp_vld"}, 32'(bus.rsp_vld), 32'(0));
        chk({pfx, "_rsp_buf"}, 32'(bus.rsp_buf), 32'(0));
        chk({pfx, "_rsp_hit"}, 32'(bus.rsp_hit), 32'(0));
        chk({pfx, "_ref_vld"}, 32'(bus.lfu_ref_vld), 32'(0));
        chk({pfx, "_ref_buf"}, 32'(bus.lfu_ref_buf), 32'(0));
        chk({pfx, "_new_req"}, 32'(bus.lfu_new_req), 32'(0));
        chk({pfx, "_req_rdy"}, 32'(bus.req_rdy), 32'(1));
    endtask

    initial begin
        int p0;
        int w;
        rst         = 1'b1;
        bus.req_vld = 1'b0;
        bus.req_tag = '0;
        bus.rsp_rdy = 1'b1;
        bus.flush   = 1'b0;
        replc_sel   = 2'd1;
        m_vld       = '0;
        for (int i = 0; i < 4; i++) m_tag[i] = '0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_rst");

        // Fill the empty pool, then hit, then two replacements with different victims.
        lookup(8'h11, 0);
        lookup(8'h22, 0);
        lookup(8'h33, 0);
        lookup(8'h44, 0);
        lookup(8'h33, 0);
        replc_sel = 2'd1;
        lookup(8'h55, 0);
        lookup(8'h55, 0);
        replc_sel = 2'd3;
        lookup(8'h22, 0);
        lookup(8'h44, 0);

        // Backpressure: rsp_rdy low for 10 response cycles on a hit.
        lookup(8'h33, 9);

        // Flush wins over a simultaneous request.
        @(negedge clk);
        p0          = n_pulse;
        bus.flush   = 1'b1;
        bus.req_vld = 1'b1;
        bus.req_tag = 8'h11;
        #1;
        chk("flush_rdy", 32'(bus.req_rdy), 32'(0));
        @(negedge clk);
        bus.flush   = 1'b0;
        bus.req_vld = 1'b0;
        m_vld       = '0;
        #1;
        chk("flush_idle", 32'(bus.req_rdy), 32'(1));
        chk("flush_no_rsp", 32'(bus.rsp_vld), 32'(0));
        chk("flush_no_pulse", n_pulse - p0, 0);
        lookup(8'h11, 0);
        lookup(8'h22, 0);
        lookup(8'h33, 0);
        lookup(8'h44, 0);

        // Reset while waiting for the victim.
        replc_sel = 2'd2;
        start_req(8'h66);
        w = 0;
        while (1) begin
            @(negedge clk);
            bus.req_vld = 1'b0;
            w++;
            if (bus.lfu_new_req || w > 10) break;
        end
        chk("alloc_seen", 32'(bus.lfu_new_req), 32'(1));
        @(negedge clk);
        chk("wait_no_rsp", 32'(bus.rsp_vld), 32'(0));
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        m_vld = '0;
        rsp_q.delete();
        pls_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("after_rst_no_rsp", 32'(bus.rsp_vld), 32'(0));
        end
        lookup(8'h11, 0);
        lookup(8'h11, 0);

        chk("pulse_q_empty", 32'(pls_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "bench timed out");
    end
endmodule
